// File: rtl/can_tx_mailbox_scheduler.sv
// can_tx_mailbox_scheduler
// Arbitrates NUM_MB transmit mailboxes onto one CAN transmit controller.
// The pending mailbox with the lowest identifier wins (ties go to the lowest
// index). The winner is handed over with a req/ack handshake, and the
// controller's outcome (done / lost / err) decides its fate. The scheduler
// re-arbitrates after every outcome, so a newly loaded higher-priority frame
// can overtake one that is being retried.
//
// Optional feature macro: CAN_RETRY_LIMIT_EN
//   defined   : per-mailbox error counter; a mailbox is dropped with a
//               fail_pulse on its MAX_RETRY-th transmit error.
//   undefined : unlimited retries, fail_pulse_o is constant 0.
//
// Handshake: tx_req_o rises with tx_id_o/tx_data_o already valid and holds
// all three stable until the first cycle tx_ack_i is seen high; that edge
// completes the transfer and tx_req_o drops. Outcome pulses (tx_done_i,
// tx_lost_i, tx_err_i) are only honoured after that handshake, in WAIT, with
// priority done > err > lost.
//
// "Active" mailbox: the one in flight (FSM in REQ or WAIT, index active_sel_o).
// Writes to it are ignored and aborts on it are latched until the outcome.
module can_tx_mailbox_scheduler #(
  parameter int NUM_MB    = 4,
  parameter int ID_W      = 11,
  parameter int DATA_W    = 8,
  parameter int MAX_RETRY = 3,
  localparam int SEL_W    = (NUM_MB > 1) ? $clog2(NUM_MB) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [SEL_W-1:0]  wr_sel_i,
  input  logic [ID_W-1:0]   wr_id_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [NUM_MB-1:0] abort_i,
  output logic              tx_req_o,
  output logic [ID_W-1:0]   tx_id_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ack_i,
  input  logic              tx_done_i,
  input  logic              tx_lost_i,
  input  logic              tx_err_i,
  output logic [NUM_MB-1:0] pending_o,
  output logic [NUM_MB-1:0] done_pulse_o,
  output logic [NUM_MB-1:0] fail_pulse_o,
  output logic              busy_o,
  output logic [SEL_W-1:0]  active_sel_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_REQ    = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  // FSM and handshake registers
  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              tx_req_q, tx_req_d;
  logic [ID_W-1:0]   tx_id_q, tx_id_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              abort_lat_q, abort_lat_d;

  // Mailbox storage
  logic [NUM_MB-1:0] pend_q, pend_d;
  logic [ID_W-1:0]   id_q   [NUM_MB];
  logic [ID_W-1:0]   id_d   [NUM_MB];
  logic [DATA_W-1:0] data_q [NUM_MB];
  logic [DATA_W-1:0] data_d [NUM_MB];

  // Status pulses
  logic [NUM_MB-1:0] done_q, done_d;
  logic [NUM_MB-1:0] fail_q, fail_d;

`ifdef CAN_RETRY_LIMIT_EN
  localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [CNT_W-1:0]  cnt_q [NUM_MB];
  logic [CNT_W-1:0]  cnt_d [NUM_MB];
`endif

  // Arbitration helpers
  logic              in_flight;
  logic [NUM_MB-1:0] wr_mask;
  logic [NUM_MB-1:0] cand;
  logic              win_found;
  logic [SEL_W-1:0]  win_sel;
  logic [ID_W-1:0]   win_id;
  logic              abort_now;

  assign in_flight = (state_q == ST_REQ) || (state_q == ST_WAIT);

  // Decode the load target into a one-hot mask
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (wr_en_i && (int'(wr_sel_i) == i)) wr_mask[i] = 1'b1;
    end
  end

  // Lowest pending id wins; strict '<' keeps the lowest index on ties. A
  // mailbox being aborted or rewritten this cycle sits out this round.
  always_comb begin
    cand      = pend_q & ~abort_i & ~wr_mask;
    win_found = 1'b0;
    win_sel   = '0;
    win_id    = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (cand[i] && (!win_found || (id_q[i] < win_id))) begin
        win_found = 1'b1;
        win_sel   = SEL_W'(i);
        win_id    = id_q[i];
      end
    end
  end

  // Next-state logic: mailbox loads/aborts, then the FSM and outcome handling
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    tx_req_d    = tx_req_q;
    tx_id_d     = tx_id_q;
    tx_data_d   = tx_data_q;
    abort_lat_d = abort_lat_q;
    pend_d      = pend_q;
    id_d        = id_q;
    data_d      = data_q;
    done_d      = '0;
    fail_d      = '0;
    abort_now   = abort_lat_q | abort_i[sel_q];
`ifdef CAN_RETRY_LIMIT_EN
    cnt_d       = cnt_q;
`endif

    // Non-active mailboxes: abort beats a same-cycle load
    for (int i = 0; i < NUM_MB; i++) begin
      if (!(in_flight && (int'(sel_q) == i))) begin
        if (abort_i[i]) begin
          pend_d[i] = 1'b0;
`ifdef CAN_RETRY_LIMIT_EN
          cnt_d[i]  = '0;
`endif
        end else if (wr_mask[i]) begin
          pend_d[i] = 1'b1;
          id_d[i]   = wr_id_i;
          data_d[i] = wr_data_i;
`ifdef CAN_RETRY_LIMIT_EN
          cnt_d[i]  = '0;
`endif
        end
      end
    end

    // Active mailbox: remember an abort until the outcome arrives
    if (in_flight && abort_i[sel_q]) abort_lat_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (|pend_q) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (win_found) begin
          sel_d       = win_sel;
          tx_req_d    = 1'b1;
          tx_id_d     = id_q[win_sel];
          tx_data_d   = data_q[win_sel];
          abort_lat_d = 1'b0;
          state_d     = ST_REQ;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (tx_ack_i) begin
          tx_req_d = 1'b0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done_i) begin
          pend_d[sel_q] = 1'b0;
          done_d[sel_q] = 1'b1;
`ifdef CAN_RETRY_LIMIT_EN
          cnt_d[sel_q]  = '0;
`endif
          state_d       = ST_IDLE;
        end else if (tx_err_i) begin
          if (abort_now) begin
            pend_d[sel_q] = 1'b0;
`ifdef CAN_RETRY_LIMIT_EN
            cnt_d[sel_q]  = '0;
`endif
          end else begin
`ifdef CAN_RETRY_LIMIT_EN
            if (cnt_q[sel_q] >= CNT_W'(MAX_RETRY - 1)) begin
              pend_d[sel_q] = 1'b0;
              fail_d[sel_q] = 1'b1;
              cnt_d[sel_q]  = '0;
            end else begin
              cnt_d[sel_q]  = cnt_q[sel_q] + 1'b1;
            end
`endif
          end
          state_d = ST_IDLE;
        end else if (tx_lost_i) begin
          if (abort_now) begin
            pend_d[sel_q] = 1'b0;
`ifdef CAN_RETRY_LIMIT_EN
            cnt_d[sel_q]  = '0;
`endif
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset empties every mailbox and drops tx_req
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      tx_req_q    <= 1'b0;
      tx_id_q     <= '0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      abort_lat_q <= 1'b0;
      pend_q      <= '0;
      done_q      <= '0;
      fail_q      <= '0;
      for (int i = 0; i < NUM_MB; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      tx_req_q    <= tx_req_d;
      tx_id_q     <= tx_id_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      abort_lat_q <= abort_lat_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      id_q        <= id_d;
      data_q      <= data_d;
    end
  end

`ifdef CAN_RETRY_LIMIT_EN
  // Per-mailbox transmit error counters
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_MB; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign fail_pulse_o = fail_q;
`else
  assign fail_pulse_o = '0;
`endif

  assign tx_req_o     = tx_req_q;
  assign tx_id_o      = tx_id_q;
  assign tx_data_o    = tx_data_q;
  assign pending_o    = pend_q;
  assign done_pulse_o = done_q;
  assign busy_o       = busy_q;
  assign active_sel_o = sel_q;
  assign state_o      = state_q;

endmodule
